// File: rtl/arith_pkg.sv
// Shared arithmetic-datapath definitions.
// Provides the serial FSM state encoding, default width and clog2.
package arith_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor: d = x - y - br_in, borrow out on br_out.
// Ports: x, y, br_in (inputs); d, br_out (outputs). Purely combinational.
module full_subtractor (
    input  logic x,
    input  logic y,
    input  logic br_in,
    output logic d,
    output logic br_out
);

    assign d      = x ^ y ^ br_in;
    assign br_out = (~x & y) | (~(x ^ y) & br_in);

endmodule

// File: rtl/serial_subtract.sv
// Bit-serial subtractor: diff = a - b - b_in, LSB first, one bit per clock.
// Ports: clk, rst_n, start, a, b, b_in in; busy, done, diff, b_out, overflow out.
module serial_subtract
    import arith_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             b_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             b_out,
    output logic             overflow
);

    localparam int CW = clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t state;
    state_t state_nxt;
    logic   accept;
    logic   last;

    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res_sh;
    logic [WIDTH-1:0] res_nxt;
    logic [CW-1:0]    cnt;
    logic             br;
    logic             d;
    logic             br_nxt;

    full_subtractor u_cell (
        .x      (a_sh[0]),
        .y      (b_sh[0]),
        .br_in  (br),
        .d      (d),
        .br_out (br_nxt)
    );

    // New bit enters at the MSB; after WIDTH shifts bit 0 is in place.
    assign res_nxt = (res_sh >> 1)
                   | ({{(WIDTH-1){1'b0}}, d} << (WIDTH - 1));

    assign busy = (state == ST_RUN);
    assign done = (state == ST_DONE);

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        last      = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (cnt == LAST) begin
                    last      = 1'b1;
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = ST_RUN;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh     <= '0;
            b_sh     <= '0;
            res_sh   <= '0;
            br       <= 1'b0;
            cnt      <= '0;
            diff     <= '0;
            b_out    <= 1'b0;
            overflow <= 1'b0;
        end else if (accept) begin
            a_sh   <= a;
            b_sh   <= b;
            br     <= b_in;
            res_sh <= '0;
            cnt    <= '0;
        end else if (state == ST_RUN) begin
            a_sh   <= a_sh >> 1;
            b_sh   <= b_sh >> 1;
            br     <= br_nxt;
            res_sh <= res_nxt;
            cnt    <= cnt + CW'(1);
            if (last) begin
                diff     <= res_nxt;
                b_out    <= br_nxt;
                // On the last bit a_sh[0]/b_sh[0] are the captured MSBs.
                overflow <= (a_sh[0] != b_sh[0]) && (d != a_sh[0]);
            end
        end
    end

endmodule

// File: tb/tb_serial_subtract.sv
// Randomized self-checking bench for serial_subtract.
// Compares against an integer-arithmetic model of a - b - b_in.
module tb_serial_subtract;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         b_in;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         b_out;
    logic         overflow;

    int total;
    int bad;

    serial_subtract #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .a        (a),
        .b        (b),
        .b_in     (b_in),
        .busy     (busy),
        .done     (done),
        .diff     (diff),
        .b_out    (b_out),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: plain integer arithmetic, signed range test for overflow.
    task automatic model(input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic bi, output logic [W-1:0] ed,
                         output logic eb, output logic eo);
        int u;
        int sx;
        int sy;
        int s;
        u  = int'(x) - int'(y) - int'(bi);
        ed = W'(u);
        eb = (u < 0);
        sx = (int'(x) >= (1 << (W - 1))) ? int'(x) - (1 << W) : int'(x);
        sy = (int'(y) >= (1 << (W - 1))) ? int'(y) - (1 << W) : int'(y);
        s  = sx - sy - int'(bi);
        eo = (s < -(1 << (W - 1))) || (s > (1 << (W - 1)) - 1);
    endtask

    task automatic check_res(input string tag, input logic [W-1:0] x,
                             input logic [W-1:0] y, input logic bi);
        logic [W-1:0] ed;
        logic eb;
        logic eo;
        model(x, y, bi, ed, eb, eo);
        check({tag, ".diff"}, 32'(diff), 32'(ed));
        check({tag, ".b_out"}, 32'(b_out), 32'(eb));
        check({tag, ".ovf"}, 32'(overflow), 32'(eo));
    endtask

    // Called #1 after an edge; returns #1 after the accepting edge.
    task automatic launch(input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic bi);
        a     = x;
        b     = y;
        b_in  = bi;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a     = W'($urandom);
        b     = W'($urandom);
        b_in  = 1'($urandom);
    endtask

    task automatic wait_done(output int cyc, output int bcnt);
        cyc  = 0;
        bcnt = 0;
        while (!done && cyc < 3 * W) begin
            if (busy) bcnt++;
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic do_op(input string tag, input logic [W-1:0] x,
                         input logic [W-1:0] y, input logic bi);
        int cyc;
        int bcnt;
        launch(x, y, bi);
        wait_done(cyc, bcnt);
        check({tag, ".lat"}, 32'(cyc), 32'(W));
        check({tag, ".busy"}, 32'(bcnt), 32'(W));
        check_res(tag, x, y, bi);
        @(posedge clk);
        #1;
        check({tag, ".pulse"}, 32'(done), 32'd0);
    endtask

    initial begin
        int cyc;
        int bcnt;
        int dcnt;
        logic [W-1:0] x;
        logic [W-1:0] y;
        logic bi;
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        b_in  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst.busy", 32'(busy), 32'd0);
        check("rst.done", 32'(done), 32'd0);
        check("rst.diff", 32'(diff), 32'd0);
        check("rst.bout", 32'(b_out), 32'd0);
        check("rst.ovf", 32'(overflow), 32'd0);

        do_op("basic", 8'h50, 8'h20, 1'b0);
        do_op("borrow", 8'h00, 8'h01, 1'b0);
        do_op("ovf", 8'h80, 8'h01, 1'b0);
        do_op("bin", 8'h7F, 8'hFF, 1'b1);
        do_op("ovf_bin", 8'h80, 8'h00, 1'b1);

        // start mid-RUN must be ignored
        launch(8'h33, 8'h11, 1'b0);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        a     = 8'hAA;
        b     = 8'h55;
        b_in  = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(cyc, bcnt);
        check("ign.lat", 32'(cyc + 4), 32'(W));
        check_res("ign", 8'h33, 8'h11, 1'b0);
        @(posedge clk);
        #1;
        check("ign.busy", 32'(busy), 32'd0);
        check("ign.done", 32'(done), 32'd0);

        // back-to-back via start held in DONE
        launch(8'h10, 8'h20, 1'b1);
        wait_done(cyc, bcnt);
        check("b2b1.lat", 32'(cyc), 32'(W));
        check_res("b2b1", 8'h10, 8'h20, 1'b1);
        launch(8'hC3, 8'h3C, 1'b0);
        check("b2b.busy", 32'(busy), 32'd1);
        wait_done(cyc, bcnt);
        check("b2b.gap", 32'(cyc + 1), 32'(W + 1));
        check_res("b2b2", 8'hC3, 8'hC3 - 8'hC3 + 8'h3C, 1'b0);
        @(posedge clk);
        #1;

        // reset in the 4th RUN cycle aborts
        launch(8'hF0, 8'h0F, 1'b0);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        rst_n = 1'b0;
        #1;
        check("abort.busy", 32'(busy), 32'd0);
        check("abort.done", 32'(done), 32'd0);
        check("abort.diff", 32'(diff), 32'd0);
        check("abort.bout", 32'(b_out), 32'd0);
        check("abort.ovf", 32'(overflow), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        dcnt  = 0;
        repeat (W + 3) begin
            @(posedge clk);
            #1;
            if (done || busy) dcnt++;
        end
        check("abort.quiet", 32'(dcnt), 32'd0);
        do_op("post", 8'h9A, 8'h5B, 1'b1);

        for (int i = 0; i < 24; i++) begin
            x  = W'($urandom);
            y  = W'($urandom);
            bi = 1'($urandom);
            do_op($sformatf("rnd%0d", i), x, y, bi);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/serial_subtract.md
Name: serial_subtract

Overview:
- Bit-serial two's-complement subtractor: diff = a - b - b_in, one bit per clock.
- Trades the area of a full ripple array for WIDTH cycles of latency.
- Uses a single full-subtractor cell and a start/busy/done handshake.
- Sits beside the combinational ripple adders as the subtract path of the arithmetic datapath.

Parameters:
- WIDTH, 8, operand/result width in bits (>= 2).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only when not busy
- a  input  WIDTH  minuend, captured on accepted start
- b  input  WIDTH  subtrahend, captured on accepted start
- b_in  input  1  borrow in, captured on accepted start
- busy  output  1  high while a subtraction is in progress
- done  output  1  one-cycle pulse, results valid
- diff  output  WIDTH  registered difference, held until next completion
- b_out  output  1  borrow out of MSB (1 = unsigned a < b + b_in)
- overflow  output  1  signed overflow of a - b - b_in

Behaviour:
- Interface: one clock, clk; reset rst_n is asynchronous, active-low.
- Reset (async assert, any state): go to IDLE.
  - busy=0, done=0, diff=0, b_out=0, overflow=0.
  - Working registers and bit counter cleared.
- States and transitions:
  - IDLE: start=1 at edge k → capture a, b, b_in, set count=0, go to RUN.
  - RUN: busy=1 for exactly WIDTH cycles (edges k+1..k+WIDTH).
    - Each edge processes bit i=count, LSB first.
    - d_i = a_i ^ b_i ^ br.
    - br_next = (~a_i & b_i) | (~(a_i ^ b_i) & br), where br starts at b_in.
    - Operand shift registers shift right; d_i is shifted into the result shift register MSB.
    - After bit WIDTH-1, go to DONE.
  - DONE: one cycle with done=1, busy=0.
    - diff, b_out and overflow update on the edge entering DONE.
    - Next state is IDLE, unless start=1 in DONE; then capture new operands and go to RUN (back-to-back, no idle gap).
- Latency: start sampled at edge k → done=1 in the cycle after edge k+WIDTH.
- Throughput: one result per WIDTH+1 cycles.
- start while busy=1: ignored. Captured operands are unaffected and no request is queued.
- Input stability: a, b and b_in may change freely after the accepting edge.
- Output hold: diff, b_out and overflow keep the previous result during RUN. They change only on completion.
- overflow = (a_msb != b_msb) & (d_msb != a_msb), using the captured operands.
- b_in is included in both the borrow chain and the signed result.
- Width rules:
  - All arithmetic is mod 2^WIDTH.
  - b_out is the final br.
  - Counter width is clog2(WIDTH)+1, saturating logic not needed.
- Reset mid-RUN aborts the operation. No done pulse is issued and outputs go to reset values.

Decomposition:
- Shared package arith_pkg:
  - state encoding (ST_IDLE, ST_RUN, ST_DONE)
  - default WIDTH constant
  - clog2 function
- One natural sub-module: full_subtractor (x, y, br_in → d, br_out), purely combinational.
  - Instantiated once; it is the serial cell.
- FSM, counter and shift registers live in serial_subtract.

Test Plan:
- Reset: hold rst_n=0, then release → busy=0, done=0, diff=8'h00, b_out=0, overflow=0.
- Basic subtraction: a=8'h50, b=8'h20, b_in=0, start pulse.
  - busy high 8 cycles, then done for 1 cycle.
  - diff=8'h30, b_out=0, overflow=0.
- Borrow and signed overflow:
  - a=8'h00, b=8'h01 → diff=8'hFF, b_out=1, overflow=0.
  - a=8'h80, b=8'h01 → diff=8'h7F, b_out=0, overflow=1.
- Borrow-in: a=8'h7F, b=8'hFF, b_in=1 → diff=8'h7F, b_out=1, overflow=0.
- Handshake:
  - start re-asserted with new operands mid-RUN → ignored; first result unchanged.
  - start held in the DONE cycle → second operation begins immediately; its done arrives 9 cycles after the first.
- Reset mid-operation: assert rst_n=0 on the 4th RUN cycle → outputs zero immediately.
  - No done pulse follows.
  - A subsequent start completes normally.
